// File: rtl/sequence_input_serializer.sv
// Word-to-bit serializer feeding the 101101 sequence detector.
// A hold register in front of the shifter lets back-to-back words stream with no gap.
module sequence_input_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  input  logic             flush,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 word_done_q, word_done_d;
  logic [CNT_W-1:0]     word_count_q, word_count_d;

  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign load_ready = ~hold_full_q & ~flush & ~reset;
  assign accept     = load_valid & load_ready;
  // Move the register one place toward the output end, zero-filling behind.
  assign shifted    = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_done_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_done_q  <= word_done_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_done_d  = 1'b0;
    word_count_d = word_count_q;

    if (flush) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      shift_d     = '0;
      bit_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (bit_cnt_q != LAST_BIT) begin
              shift_d   = shifted;
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
              word_done_d  = 1'b1;
              word_count_d = word_count_q + CNT_W'(1);
              // A buffered word is reloaded on the same edge for a gapless stream.
              if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                bit_cnt_d   = '0;
              end else begin
                shift_d = shifted;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // accept implies the hold register was empty, so it never races the reload.
      if (accept) begin
        hold_d      = load_data;
        hold_full_d = 1'b1;
      end
    end
  end

  assign X          = (state_q == SHIFT) & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign x_valid    = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT) | hold_full_q;
  assign word_done  = word_done_q;
  assign word_count = word_count_q;

endmodule
